// File: rtl/mem_arbiter_rr.sv
// N-channel request/ack arbiter that serialises cache-side masters onto one synchronous
// memory port; fixed-priority or round-robin selection, optional BUSY timeout with error pulse.
module mem_arbiter_rr #(
  parameter int unsigned N_CH    = 3,
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH-1:0]         rw,
  input  logic [N_CH*ADDR_W-1:0]  addr,
  input  logic [N_CH*WIDTH-1:0]   wdata,
  output logic [N_CH-1:0]         ack,
  output logic [WIDTH-1:0]        rdata,
  output logic                    err,
  output logic [$clog2(N_CH)-1:0] grant_id,
  output logic                    mem_enable,
  output logic                    mem_rw,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WIDTH-1:0]        mem_data_in,
  input  logic [WIDTH-1:0]        mem_data_out,
  input  logic                    mem_ack
);

  localparam int unsigned ID_W    = $clog2(N_CH);
  localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state, state_d;
  logic [ID_W-1:0]   last_grant, last_grant_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ID_W-1:0]   win, cand;
  logic              found;

  logic [N_CH-1:0]   ack_d;
  logic [WIDTH-1:0]  rdata_d;
  logic              err_d;
  logic [ID_W-1:0]   grant_id_d;
  logic              mem_enable_d;
  logic              mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [WIDTH-1:0]  mem_data_in_d;

  // Winner select: scan from channel 0 (fixed) or from the one after the last grant (RR).
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (RR_MODE != 0) cand = ID_W'((32'(last_grant) + 32'd1 + i) % N_CH);
      else              cand = ID_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d       = state;
    last_grant_d  = last_grant;
    cnt_d         = cnt;
    ack_d         = '0;
    err_d         = 1'b0;
    rdata_d       = rdata;
    grant_id_d    = grant_id;
    mem_enable_d  = mem_enable;
    mem_rw_d      = mem_rw;
    mem_addr_d    = mem_addr;
    mem_data_in_d = mem_data_in;
    case (state)
      S_IDLE: begin
        if (|req) begin
          state_d       = S_BUSY;
          grant_id_d    = win;
          mem_enable_d  = 1'b1;
          mem_rw_d      = rw[win];
          mem_addr_d    = addr[32'(win) * ADDR_W +: ADDR_W];
          mem_data_in_d = rw[win] ? '0 : wdata[32'(win) * WIDTH +: WIDTH];
          cnt_d         = '0;
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          state_d      = S_DONE;
          mem_enable_d = 1'b0;
          ack_d        = N_CH'(1) << grant_id;
          if (mem_rw) rdata_d = mem_data_out;
        end else if (TIMEOUT != 0) begin
          if (cnt == CNT_W'(TO_LAST)) begin
            state_d      = S_DONE;
            mem_enable_d = 1'b0;
            ack_d        = N_CH'(1) << grant_id;
            err_d        = 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        last_grant_d = grant_id;
        cnt_d        = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      last_grant  <= ID_W'(N_CH - 1);
      cnt         <= '0;
      ack         <= '0;
      rdata       <= '0;
      err         <= 1'b0;
      grant_id    <= '0;
      mem_enable  <= 1'b0;
      mem_rw      <= 1'b1;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else begin
      state       <= state_d;
      last_grant  <= last_grant_d;
      cnt         <= cnt_d;
      ack         <= ack_d;
      rdata       <= rdata_d;
      err         <= err_d;
      grant_id    <= grant_id_d;
      mem_enable  <= mem_enable_d;
      mem_rw      <= mem_rw_d;
      mem_addr    <= mem_addr_d;
      mem_data_in <= mem_data_in_d;
    end
  end

endmodule
